// File: rtl/scene_fade_ctrl.sv
// Scene sequencer: fades to black over whole frames, swaps the scene
// ROM select while dark, fades back in, and scales the palette RGB.
module scene_fade_ctrl #(
  parameter int NUM_SCENES      = 4,
  parameter int SCENE_W         = 2,
  parameter int INIT_SCENE      = 0,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               vs,
  input  logic               blank,
  input  logic               req_valid,
  input  logic [SCENE_W-1:0] req_scene,
  output logic               req_ready,
  output logic [SCENE_W-1:0] cur_scene,
  output logic               busy,
  output logic [4:0]         brightness,
  input  logic [3:0]         red_in,
  input  logic [3:0]         green_in,
  input  logic [3:0]         blue_in,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    SWAP,
    FADE_IN
  } state_t;

  localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [SCENE_W-1:0] INIT = SCENE_W'(INIT_SCENE);

  state_t             state, state_n;
  logic [4:0]         bright_n;
  logic [7:0]         fcnt, fcnt_n;
  logic [SCENE_W-1:0] pending, pending_n;
  logic [SCENE_W-1:0] scene_n;
  logic               vs_q;
  logic               fe;
  logic               step;
  logic               legal;

  assign fe        = vs_q & ~vs;
  assign step      = (fcnt == STEP_LAST);
  assign legal     = (int'(req_scene) < NUM_SCENES) &&
                     (req_scene != cur_scene);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n   = state;
    bright_n  = brightness;
    fcnt_n    = fcnt;
    pending_n = pending;
    scene_n   = cur_scene;
    unique case (state)
      IDLE: begin
        if (req_valid && legal) begin
          pending_n = req_scene;
          fcnt_n    = 8'd0;
          state_n   = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (fe) begin
          if (step) begin
            bright_n = brightness - 5'd1;
            fcnt_n   = 8'd0;
            if (brightness == 5'd1)
              state_n = SWAP;
          end else begin
            fcnt_n = fcnt + 8'd1;
          end
        end
      end
      SWAP: begin
        if (fe) begin
          scene_n = pending;
          fcnt_n  = 8'd0;
          state_n = FADE_IN;
        end
      end
      FADE_IN: begin
        if (fe) begin
          if (step) begin
            bright_n = brightness + 5'd1;
            fcnt_n   = 8'd0;
            if (brightness == 5'd15)
              state_n = IDLE;
          end else begin
            fcnt_n = fcnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      brightness <= 5'd16;
      fcnt       <= 8'd0;
      pending    <= INIT;
      cur_scene  <= INIT;
      vs_q       <= 1'b1;
    end else begin
      state      <= state_n;
      brightness <= bright_n;
      fcnt       <= fcnt_n;
      pending    <= pending_n;
      cur_scene  <= scene_n;
      vs_q       <= vs;
    end
  end

  // 4-bit colour times 0..16 gain; bits [7:4] make gain 16 a pass-through
  function automatic logic [3:0] scale(input logic [3:0] c,
                                       input logic [4:0] g);
    logic [8:0] p;
    p = {5'd0, c} * {4'd0, g};
    return p[7:4];
  endfunction

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end else if (blank) begin
      red   <= scale(red_in, brightness);
      green <= scale(green_in, brightness);
      blue  <= scale(blue_in, brightness);
    end else begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end
  end

endmodule

// File: tb/tb_scene_fade_ctrl.sv
// Scoreboard bench for scene_fade_ctrl: stimulus queues expectations,
// a monitor pops and compares them after each clock edge.
module tb_scene_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst1, rst3;
  logic       vs, blank;
  logic [3:0] rin, gin, bin;
  logic       rv1, rv3;
  logic [1:0] rs1, rs3;

  logic       rdy1, busy1, rdy3, busy3;
  logic [1:0] cs1, cs3;
  logic [4:0] bri1, bri3;
  logic [3:0] r1, g1, b1, r3, g3, b3;

  always #5 clk = ~clk;

  scene_fade_ctrl dut1 (
    .vga_clk(clk), .reset_n(rst1), .vs(vs), .blank(blank),
    .req_valid(rv1), .req_scene(rs1), .req_ready(rdy1),
    .cur_scene(cs1), .busy(busy1), .brightness(bri1),
    .red_in(rin), .green_in(gin), .blue_in(bin),
    .red(r1), .green(g1), .blue(b1)
  );

  scene_fade_ctrl #(
    .NUM_SCENES(3), .SCENE_W(2), .INIT_SCENE(1), .FRAMES_PER_STEP(3)
  ) dut3 (
    .vga_clk(clk), .reset_n(rst3), .vs(vs), .blank(blank),
    .req_valid(rv3), .req_scene(rs3), .req_ready(rdy3),
    .cur_scene(cs3), .busy(busy3), .brightness(bri3),
    .red_in(rin), .green_in(gin), .blue_in(bin),
    .red(r3), .green(g3), .blue(b3)
  );

  typedef struct {
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  localparam int BRI1 = 0, CS1 = 1, BUSY1 = 2, RDY1 = 3;
  localparam int RED1 = 4, GRN1 = 5, BLU1 = 6;
  localparam int BRI3 = 10, CS3 = 11, BUSY3 = 12, RDY3 = 13;

  function automatic int get(input int sel);
    case (sel)
      BRI1:    return int'(bri1);
      CS1:     return int'(cs1);
      BUSY1:   return int'(busy1);
      RDY1:    return int'(rdy1);
      RED1:    return int'(r1);
      GRN1:    return int'(g1);
      BLU1:    return int'(b1);
      BRI3:    return int'(bri3);
      CS3:     return int'(cs3);
      BUSY3:   return int'(busy3);
      RDY3:    return int'(rdy3);
      default: return -1;
    endcase
  endfunction

  function automatic void expect_v(input string n, input int s,
                                   input int v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.val  = v;
    q.push_back(e);
  endfunction

  always @(posedge clk) begin
    #2;
    while (q.size() > 0) begin
      exp_t e;
      int   got;
      e   = q.pop_front();
      got = get(e.sel);
      checks++;
      if (got != e.val) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, got, e.val);
      end
    end
  end

  task automatic clear_req();
    rv1 = 1'b0;
    rv3 = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    clear_req();
    vs = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vs = 1'b0;
    @(posedge clk);
  endtask

  task automatic req1(input logic [1:0] s);
    @(negedge clk);
    clear_req();
    rv1 = 1'b1;
    rs1 = s;
    @(posedge clk);
  endtask

  task automatic req3(input logic [1:0] s);
    @(negedge clk);
    clear_req();
    rv3 = 1'b1;
    rs3 = s;
    @(posedge clk);
  endtask

  task automatic pix(input logic bl, input logic [3:0] r,
                     input logic [3:0] g, input logic [3:0] b);
    @(negedge clk);
    clear_req();
    blank = bl;
    rin   = r;
    gin   = g;
    bin   = b;
    @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b0; rst3 = 1'b0;
    vs = 1'b1; blank = 1'b0;
    rin = 4'd0; gin = 4'd0; bin = 4'd0;
    rv1 = 1'b0; rv3 = 1'b0; rs1 = 2'd0; rs3 = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b1; rst3 = 1'b1;
    @(posedge clk);
    expect_v("rst_bri", BRI1, 16);
    expect_v("rst_cs", CS1, 0);
    expect_v("rst_busy", BUSY1, 0);
    expect_v("rst_rdy", RDY1, 1);
    expect_v("rst_red", RED1, 0);
    expect_v("rst_cs3", CS3, 1);
    expect_v("rst_bri3", BRI3, 16);

    pix(1'b1, 4'hA, 4'h5, 4'hF);
    expect_v("pix_g16_r", RED1, 10);
    expect_v("pix_g16_g", GRN1, 5);
    expect_v("pix_g16_b", BLU1, 15);
    pix(1'b0, 4'hA, 4'h5, 4'hF);
    expect_v("pix_blank_r", RED1, 0);
    expect_v("pix_blank_b", BLU1, 0);

    req1(2'd0);
    expect_v("same_busy", BUSY1, 0);
    expect_v("same_rdy", RDY1, 1);
    repeat (5) frame();
    expect_v("same_cs", CS1, 0);
    expect_v("same_busy5", BUSY1, 0);

    req1(2'd2);
    expect_v("acc_busy", BUSY1, 1);
    expect_v("acc_rdy", RDY1, 0);
    expect_v("acc_bri", BRI1, 16);
    for (int i = 1; i <= 40; i++) begin
      frame();
      if (i <= 16) expect_v("fo_bri", BRI1, 16 - i);
      if (i == 16) expect_v("fo_cs", CS1, 0);
      if (i == 17) begin
        expect_v("sw_cs", CS1, 2);
        expect_v("sw_bri", BRI1, 0);
      end
      if (i >= 18 && i <= 33) expect_v("fi_bri", BRI1, i - 17);
      if (i == 32) expect_v("fi_busy", BUSY1, 1);
      if (i == 33) begin
        expect_v("done_busy", BUSY1, 0);
        expect_v("done_rdy", RDY1, 1);
      end
      if (i == 3) begin
        req1(2'd3);
        expect_v("busy_req_rdy", RDY1, 0);
        expect_v("busy_req_bri", BRI1, 13);
      end
      if (i == 8) begin
        pix(1'b1, 4'hF, 4'h3, 4'hA);
        expect_v("pix_g8_r", RED1, 7);
        expect_v("pix_g8_g", GRN1, 1);
        expect_v("pix_g8_b", BLU1, 5);
        pix(1'b0, 4'hF, 4'h3, 4'hA);
        expect_v("pix_g8_blank", RED1, 0);
      end
    end
    expect_v("final_cs", CS1, 2);
    expect_v("final_busy", BUSY1, 0);

    req1(2'd1);
    expect_v("r2_busy", BUSY1, 1);
    repeat (4) frame();
    pix(1'b1, 4'hF, 4'hF, 4'hF);
    expect_v("pix_g12_r", RED1, 11);
    @(negedge clk);
    rst1 = 1'b0;
    @(posedge clk);
    expect_v("mid_rst_cs", CS1, 0);
    expect_v("mid_rst_bri", BRI1, 16);
    expect_v("mid_rst_red", RED1, 0);
    expect_v("mid_rst_rdy", RDY1, 1);
    expect_v("mid_rst_busy", BUSY1, 0);
    @(negedge clk);
    rst1 = 1'b1;
    blank = 1'b0;

    req3(2'd3);
    expect_v("oor_busy3", BUSY3, 0);
    req3(2'd1);
    expect_v("same_busy3", BUSY3, 0);
    repeat (5) frame();
    expect_v("noeff_cs3", CS3, 1);
    expect_v("noeff_busy3", BUSY3, 0);

    req3(2'd0);
    expect_v("acc_busy3", BUSY3, 1);
    expect_v("acc_rdy3", RDY3, 0);
    for (int i = 1; i <= 48; i++) begin
      frame();
      expect_v("fo3_bri", BRI3, 16 - i / 3);
    end
    expect_v("swap3_busy", BUSY3, 1);
    expect_v("swap3_cs", CS3, 1);
    @(negedge clk);
    rst3 = 1'b0;
    @(posedge clk);
    expect_v("swap_rst_cs3", CS3, 1);
    expect_v("swap_rst_bri3", BRI3, 16);
    expect_v("swap_rst_busy3", BUSY3, 0);
    expect_v("swap_rst_rdy3", RDY3, 1);
    @(negedge clk);
    rst3 = 1'b1;
    frame();
    expect_v("post_rst_cs3", CS3, 1);
    expect_v("post_rst_busy3", BUSY3, 0);

    repeat (2) @(posedge clk);
    #4;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", q.size());
      errors++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
